// File: rtl/vga_scan_engine_if.sv
// Pixel-path bundle of the scan engine: framebuffer read port, page-flip request, VGA pins and status.
interface vga_scan_engine_if #(
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned ADDR_W = 16
);
    logic              base_wr;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic [PIX_W-1:0]  pix;
    logic              de;
    logic              hs;
    logic              vs;
    logic              frame_start;
    logic              vblank;
    logic              flip_done;

    modport master (
        input  base_wr, base_addr, rd_data,
        output rd_addr, pix, de, hs, vs, frame_start, vblank, flip_done
    );

    modport slave (
        output base_wr, base_addr, rd_data,
        input  rd_addr, pix, de, hs, vs, frame_start, vblank, flip_done
    );
endinterface

// File: rtl/vga_scan_engine.sv
// Parametrised raster scan engine: h/v timing, replicated framebuffer addressing,
// frame-boundary page flip, and outputs aligned to the memory read latency.
module vga_scan_engine #(
    parameter int unsigned H_ACTIVE   = 320,
    parameter int unsigned H_FP       = 8,
    parameter int unsigned H_SYNC     = 48,
    parameter int unsigned H_BP       = 24,
    parameter int unsigned V_ACTIVE   = 400,
    parameter int unsigned V_FP       = 12,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 35,
    parameter int unsigned H_SCALE    = 1,
    parameter int unsigned V_SCALE    = 2,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned PIX_W      = 12,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic               vga_clk,
    input  logic               vga_rst_n,
    vga_scan_engine_if.master  bus
);
    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FB_W  = H_ACTIVE / H_SCALE;
    localparam int unsigned HW    = $clog2(H_TOT + 1);
    localparam int unsigned VW    = $clog2(V_TOT + 1);
    localparam int unsigned HSW   = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int unsigned VSW   = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
    localparam int unsigned LAT   = RD_LATENCY;

    localparam logic [HW-1:0]     H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0]     H_ACT_N = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0]     V_ACT_N = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HSW-1:0]    HSUB_LAST = HSW'(H_SCALE - 1);
    localparam logic [VSW-1:0]    VSUB_LAST = VSW'(V_SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_W);

    if (H_SCALE == 0 || (H_ACTIVE % H_SCALE) != 0) begin : g_bad_hscale
        $error("vga_scan_engine: H_SCALE must divide H_ACTIVE");
    end
    if (V_SCALE == 0 || (V_ACTIVE % V_SCALE) != 0) begin : g_bad_vscale
        $error("vga_scan_engine: V_SCALE must divide V_ACTIVE");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("vga_scan_engine: RD_LATENCY must be in 1..4");
    end

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [HSW-1:0]    hsub_q, hsub_d;
    logic [VSW-1:0]    vsub_q, vsub_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] cur_base_q, cur_base_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LAT:0]      de_sr_q, de_sr_d, hs_sr_q, hs_sr_d;
    logic [LAT:0]      vs_sr_q, vs_sr_d, fs_sr_q, fs_sr_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic              fs_q, fs_d, vblank_q, vblank_d, flip_done_q, flip_done_d;

    logic h_last, v_last, h_act, v_act, act, frame_end;
    logic hs_now, vs_now, fs_now;

    // Counters, address generation, page flip and the alignment chains.
    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        hsub_d      = hsub_q;
        vsub_d      = vsub_q;
        col_d       = col_q;
        row_d       = row_q;
        cur_base_d  = cur_base_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        rd_addr_d   = rd_addr_q;
        flip_done_d = 1'b0;

        h_last    = (h_q == H_LAST);
        v_last    = (v_q == V_LAST);
        h_act     = (h_q < H_ACT_N);
        v_act     = (v_q < V_ACT_N);
        act       = h_act && v_act;
        frame_end = h_last && v_last;
        hs_now    = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
        vs_now    = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
        fs_now    = (h_q == '0) && (v_q == '0);

        h_d = h_last ? '0 : h_q + HW'(1);
        if (h_last) begin
            v_d = v_last ? '0 : v_q + VW'(1);
        end

        // Column steps once per H_SCALE active pixels; restarts each line.
        if (h_last) begin
            col_d  = '0;
            hsub_d = '0;
        end else if (h_act) begin
            if (hsub_q == HSUB_LAST) begin
                hsub_d = '0;
                col_d  = col_q + ADDR_W'(1);
            end else begin
                hsub_d = hsub_q + HSW'(1);
            end
        end

        // Row base steps by one framebuffer line per V_SCALE active lines.
        if (frame_end) begin
            row_d  = '0;
            vsub_d = '0;
        end else if (h_last && v_act) begin
            if (vsub_q == VSUB_LAST) begin
                vsub_d = '0;
                row_d  = row_q + ROW_STEP;
            end else begin
                vsub_d = vsub_q + VSW'(1);
            end
        end

        // A same-cycle request on the frame's last cycle beats a queued one.
        if (frame_end) begin
            if (bus.base_wr) begin
                cur_base_d  = bus.base_addr;
                flip_done_d = 1'b1;
            end else if (pend_vld_q) begin
                cur_base_d  = pend_q;
                flip_done_d = 1'b1;
            end
            pend_vld_d = 1'b0;
        end else if (bus.base_wr) begin
            pend_d     = bus.base_addr;
            pend_vld_d = 1'b1;
        end

        if (act) begin
            rd_addr_d = cur_base_q + row_q + col_q;
        end

        de_sr_d = (de_sr_q << 1) | (LAT+1)'(act);
        hs_sr_d = (hs_sr_q << 1) | (LAT+1)'(hs_now);
        vs_sr_d = (vs_sr_q << 1) | (LAT+1)'(vs_now);
        fs_sr_d = (fs_sr_q << 1) | (LAT+1)'(fs_now);

        de_d     = de_sr_q[LAT];
        hs_d     = hs_sr_q[LAT];
        vs_d     = vs_sr_q[LAT];
        fs_d     = fs_sr_q[LAT];
        pix_d    = de_sr_q[LAT] ? bus.rd_data : '0;
        vblank_d = (v_d >= V_ACT_N);
    end

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            h_q         <= '0;
            v_q         <= '0;
            hsub_q      <= '0;
            vsub_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cur_base_q  <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            rd_addr_q   <= '0;
            de_sr_q     <= '0;
            hs_sr_q     <= {(LAT+1){~HS_POL}};
            vs_sr_q     <= {(LAT+1){~VS_POL}};
            fs_sr_q     <= '0;
            pix_q       <= '0;
            de_q        <= 1'b0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            fs_q        <= 1'b0;
            vblank_q    <= 1'b0;
            flip_done_q <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            hsub_q      <= hsub_d;
            vsub_q      <= vsub_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cur_base_q  <= cur_base_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            rd_addr_q   <= rd_addr_d;
            de_sr_q     <= de_sr_d;
            hs_sr_q     <= hs_sr_d;
            vs_sr_q     <= vs_sr_d;
            fs_sr_q     <= fs_sr_d;
            pix_q       <= pix_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
            vblank_q    <= vblank_d;
            flip_done_q <= flip_done_d;
        end
    end

    assign bus.rd_addr     = rd_addr_q;
    assign bus.pix         = pix_q;
    assign bus.de          = de_q;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.frame_start = fs_q;
    assign bus.vblank      = vblank_q;
    assign bus.flip_done   = flip_done_q;
endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: small raster, 2x2 replication, latency 3, random page flips,
// outputs compared every cycle against a frame-arithmetic reference model.
module tb_vga_scan_engine;
    localparam int unsigned HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int unsigned VA = 8, VFP = 1, VSY = 2, VBP = 1;
    localparam int unsigned HSC = 2, VSC = 2, PW = 12, AW = 16, LAT = 3;
    localparam bit          HSP = 1'b0, VSP = 1'b1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FR  = HT * VT;
    localparam int FBW = HA / HSC;

    logic clk, rst_n;
    vga_scan_engine_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

    vga_scan_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .H_SCALE(HSC), .V_SCALE(VSC), .HS_POL(HSP), .VS_POL(VSP),
        .PIX_W(PW), .ADDR_W(AW), .RD_LATENCY(LAT)
    ) dut (
        .vga_clk  (clk),
        .vga_rst_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mem_f(input logic [AW-1:0] a);
        return PW'(a) ^ PW'(12'hA5C);
    endfunction

    // Memory with LAT cycles of read latency.
    logic [AW-1:0] apipe [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) apipe[i] <= '0;
        end else begin
            apipe[0] <= bus.rd_addr;
            for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
        end
    end
    assign bus.rd_data = mem_f(apipe[LAT-1]);

    int            k, n_chk, n_err;
    logic [AW-1:0] fbase [16];
    logic [AW-1:0] pend, last_addr;
    bit            pv, flip_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    function automatic bit act(input int t);
        return (t % HT) < HA && ((t / HT) % VT) < VA;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int t);
        int h = t % HT;
        int v = (t / HT) % VT;
        return fbase[t / FR] + AW'((v / VSC) * FBW + h / HSC);
    endfunction

    task automatic chk_rst();
        chk("rst_de", 32'(bus.de), 32'(0));
        chk("rst_hs", 32'(bus.hs), 32'(!HSP));
        chk("rst_vs", 32'(bus.vs), 32'(!VSP));
        chk("rst_pix", 32'(bus.pix), 32'(0));
        chk("rst_fs", 32'(bus.frame_start), 32'(0));
        chk("rst_flip", 32'(bus.flip_done), 32'(0));
        chk("rst_vblank", 32'(bus.vblank), 32'(0));
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'(0));
    endtask

    task automatic check_cycle();
        int            t = k - 2 - int'(LAT);
        logic          e_de = 1'b0, e_hs = !HSP, e_vs = !VSP, e_fs = 1'b0;
        logic [PW-1:0] e_pix = '0;
        if (t >= 0) begin
            int h = t % HT;
            int v = (t / HT) % VT;
            e_de = act(t);
            e_hs = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : !HSP;
            e_vs = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : !VSP;
            e_fs = (h == 0 && v == 0);
            if (e_de) e_pix = mem_f(addr_of(t));
        end
        if (k >= 1 && act(k - 1)) last_addr = addr_of(k - 1);
        chk("de", 32'(bus.de), 32'(e_de));
        chk("hs", 32'(bus.hs), 32'(e_hs));
        chk("vs", 32'(bus.vs), 32'(e_vs));
        chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
        chk("pix", 32'(bus.pix), 32'(e_pix));
        chk("rd_addr", 32'(bus.rd_addr), 32'(last_addr));
        chk("vblank", 32'(bus.vblank), 32'(((k / HT) % VT) >= VA));
        chk("flip_done", 32'(bus.flip_done), 32'(flip_exp));
    endtask

    // Page-flip rules applied to the request presented during cycle k.
    task automatic model_update(input bit wr, input logic [AW-1:0] a);
        flip_exp = 1'b0;
        if (k % FR == FR - 1) begin
            if (wr) begin
                fbase[k / FR + 1] = a;
                flip_exp = 1'b1;
            end else if (pv) begin
                fbase[k / FR + 1] = pend;
                flip_exp = 1'b1;
            end else begin
                fbase[k / FR + 1] = fbase[k / FR];
            end
            pv = 1'b0;
        end else if (wr) begin
            pend = a;
            pv   = 1'b1;
        end
    endtask

    task automatic step(input bit wr, input logic [AW-1:0] a);
        @(posedge clk);
        k++;
        @(negedge clk);
        check_cycle();
        bus.base_wr   = wr;
        bus.base_addr = wr ? a : '0;
        model_update(wr, a);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        k         = 0;
        pv        = 1'b0;
        pend      = '0;
        flip_exp  = 1'b0;
        last_addr = '0;
        fbase[0]  = '0;
        #1;
        check_cycle();
        bus.base_wr = 1'b0;
        model_update(1'b0, '0);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        bus.base_wr = 1'b0;
        bus.base_addr = '0;
        n_chk = 0;
        n_err = 0;
        k = 0;
        repeat (3) begin
            @(negedge clk);
            chk_rst();
        end
        release_reset();

        // Directed flips: last-wins pair, override of a queued base at the frame edge with a wrapping base.
        for (int i = 1; i < 6 * FR + 5 * HT + 10; i++) begin
            bit            wr = 1'b0;
            logic [AW-1:0] a  = '0;
            if (i == 100)                    begin wr = 1'b1; a = 16'h8000; end
            else if (i == 102)               begin wr = 1'b1; a = 16'h4000; end
            else if (i == 2 * FR - 40)       begin wr = 1'b1; a = 16'h1111; end
            else if (i == 2 * FR - 1)        begin wr = 1'b1; a = 16'hFFF8; end
            else if (i == 6 * FR + 20)       begin wr = 1'b1; a = 16'h7777; end
            else if (i >= 3 * FR && i < 6 * FR && $urandom_range(0, 47) == 0) begin
                wr = 1'b1;
                a  = AW'($urandom);
            end
            step(wr, a);
        end

        // Mid-frame reset with a flip still queued.
        #2 rst_n = 1'b0;
        #1 chk_rst();
        repeat (4) begin
            @(negedge clk);
            chk_rst();
        end
        release_reset();

        for (int i = 1; i < 3 * FR; i++) begin
            bit            wr = 1'b0;
            logic [AW-1:0] a  = '0;
            if (i >= FR && $urandom_range(0, 39) == 0) begin
                wr = 1'b1;
                a  = AW'($urandom);
            end
            step(wr, a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
